// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Streaming RV32I immediate encoder: the inverse of the datapath sign-extender.
// Each input carries a format code, a signed byte immediate and a base
// instruction word holding the non-immediate fields. The immediate is range /
// alignment checked in stage 1 and scattered into the I/S/B/J bit positions of
// the base word in stage 2. Finished words leave with a running byte address.
// Words that fail the check are still emitted (truncated bits, err=1).
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. The producer holds valid and its data stable until
// the transfer; out_valid never depends combinationally on out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous flush of pipeline, address and error count
//   in_valid/in_ready   input handshake
//   fmt                 0=I, 1=S, 2=B, 3=J
//   imm                 signed immediate (bytes)
//   base                instruction word; immediate bit positions ignored
//   out_valid/out_ready output handshake
//   instr, err          encoded word and its range/alignment violation flag
//   out_addr            byte address of the word on instr
//   err_cnt             saturating count of emitted words with err=1
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [31:0]       imm,
  input  logic [31:0]       base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic              err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  // Whole pipeline advances together; a stalled output freezes both stages,
  // so nothing is overwritten and no bubble is inserted.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en || clr;

  // ---------------------------------------------------------------------------
  // Stage 1: capture and range/alignment check
  // ---------------------------------------------------------------------------
  logic        in_err;
  logic        s1_valid;
  fmt_e        s1_fmt;
  logic [20:0] s1_imm;   // J uses the widest field, imm[20:0]
  logic [31:0] s1_base;
  logic        s1_err;

  // An immediate fits an N-bit signed field when its bits [31:N-1] are all
  // copies of the sign bit.
  always_comb begin
    in_err = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: in_err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        in_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        in_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      in_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FMT_I;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt  <= fmt_e'(fmt);
        s1_imm  <= imm[20:0];
        s1_base <= base;
        s1_err  <= in_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: scatter immediate into the base word
  // ---------------------------------------------------------------------------
  logic [31:0] merged;

  always_comb begin
    merged = s1_base;
    case (s1_fmt)
      FMT_I: begin
        merged[31:20] = s1_imm[11:0];
      end
      FMT_S: begin
        merged[31:25] = s1_imm[11:5];
        merged[11:7]  = s1_imm[4:0];
      end
      FMT_B: begin
        merged[31]    = s1_imm[12];
        merged[30:25] = s1_imm[10:5];
        merged[11:8]  = s1_imm[4:1];
        merged[7]     = s1_imm[11];
      end
      FMT_J: begin
        merged[31]    = s1_imm[20];
        merged[30:21] = s1_imm[10:1];
        merged[20]    = s1_imm[11];
        merged[19:12] = s1_imm[19:12];
      end
      default: merged = s1_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= '0;
      err       <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr <= merged;
        err   <= s1_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address and error counter: both step on the output handshake edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= BASE_ADDR;
      err_cnt  <= '0;
    end else if (clr) begin
      out_addr <= BASE_ADDR;
      err_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      out_addr <= out_addr + ADDR_W'(4);
      if (err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder: self-checking bench for imm_encoder. A second instance with a
// 4-bit address and base 8 shares the inputs and is used for address wrap.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  fmt = 2'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] base = 32'd0;

  logic        in_ready, out_valid, err;
  logic [31:0] instr, out_addr;
  logic [7:0]  err_cnt;

  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_instr;
  logic [3:0]  w_addr;
  logic [7:0]  w_cnt;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .imm(imm), .base(base),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .out_addr(out_addr), .err_cnt(err_cnt)
  );

  imm_encoder #(.ADDR_W(4), .BASE_ADDR(4'd8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .imm(imm), .base(base),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .instr(w_instr), .err(w_err), .out_addr(w_addr), .err_cnt(w_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          asserts = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];        // {err, instr}
  logic [31:0] m_addr = 32'd0;
  logic [7:0]  m_cnt = 8'd0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;
  logic [32:0] e;

  // Reference encoder written from the field tables with masks and shifts.
  function automatic logic [32:0] model(input logic [1:0] f, input logic [31:0] i,
                                        input logic [31:0] b);
    logic [31:0] w;
    logic        er;
    int          si;
    si = $signed(i);
    case (f)
      2'd0: begin
        w  = (b & 32'h000F_FFFF) | (i << 20);
        er = (si < -2048) || (si > 2047);
      end
      2'd1: begin
        w  = (b & 32'h01FF_F07F) | ((i & 32'h0000_0FE0) << 20) | ((i & 32'h0000_001F) << 7);
        er = (si < -2048) || (si > 2047);
      end
      2'd2: begin
        w  = (b & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
           | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
        er = (si < -4096) || (si > 4095) || i[0];
      end
      default: begin
        w  = (b & 32'h0000_0FFF) | (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
           | (((i >> 11) & 32'h1) << 20) | (i & 32'h000F_F000);
        er = (si < -1048576) || (si > 1048575) || i[0];
      end
    endcase
    return {er, w};
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       r = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
      2:       r = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Output monitor: pops one expectation per output handshake, checks address
  // and counter against the running model, and checks stall stability.
  always @(negedge clk) begin
    if (rst_n && !clr && prev_stall && out_valid) begin
      asserts++;
      if ({instr, err, out_addr} !== {prev_instr, prev_err, prev_addr}) begin
        fails++;
        $display("FAIL stall_hold: instr=%h err=%b addr=%h, held values %h %b %h",
                 instr, err, out_addr, prev_instr, prev_err, prev_addr);
      end
    end
    if (rst_n && !clr && out_valid && out_ready) begin
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: instr=%h err=%b, expected no word", instr, err);
        e = {err, instr};
      end else begin
        e = exp_q.pop_front();
        if ({err, instr} !== e) begin
          fails++;
          $display("FAIL word: instr=%h err=%b, expected instr=%h err=%b",
                   instr, err, e[31:0], e[32]);
        end
      end
      asserts++;
      if (out_addr !== m_addr) begin
        fails++;
        $display("FAIL out_addr: got %h, expected %h", out_addr, m_addr);
      end
      asserts++;
      if (err_cnt !== m_cnt) begin
        fails++;
        $display("FAIL err_cnt: got %0d, expected %0d", err_cnt, m_cnt);
      end
      m_addr = m_addr + 32'd4;
      if (e[32] && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    prev_stall = rst_n && !clr && out_valid && !out_ready;
    prev_instr = instr;
    prev_err   = err;
    prev_addr  = out_addr;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [1:0] f, input logic [31:0] i, input logic [31:0] b,
                      input logic [32:0] ex);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    fmt = f; imm = i; base = b; in_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready && !clr;
      if (acc) exp_q.push_back(ex);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      asserts++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, guard);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if ({out_valid, instr, err, out_addr, err_cnt, in_ready} !== {1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: valid=%b instr=%h err=%b addr=%h cnt=%0d rdy=%b, expected 0 0 0 0 0 1",
               out_valid, instr, err, out_addr, err_cnt, in_ready);
    end
    asserts++;
    if (w_addr !== 4'd8) begin
      fails++;
      $display("FAIL reset_base_addr: got %h, expected 8", w_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_encode();
    out_ready = 1'b1;
    fork
      begin
        send(2'd0, 32'd100,  32'h0000_0293, {1'b0, 32'h0640_0293});
        send(2'd1, 32'd4,    32'h0050_2023, {1'b0, 32'h0050_2223});
        send(2'd2, 32'd16,   32'h0020_8063, {1'b0, 32'h0020_8863});
        send(2'd3, 32'd1024, 32'h0000_00EF, {1'b0, 32'h4000_00EF});
      end
      begin
        // Words accepted on consecutive edges show up two cycles later, back to back.
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          asserts++;
          if (out_valid !== ((c >= 2) && (c <= 5))) begin
            fails++;
            $display("FAIL latency: cycle %0d out_valid=%b, expected %b", c, out_valid,
                     (c >= 2) && (c <= 5));
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_errors();
    send(2'd0, 32'd2048,       32'h0000_0293, {1'b1, 32'h8000_0293});
    send(2'd2, 32'd17,         32'h0020_8063, model(2'd2, 32'd17, 32'h0020_8063));
    send(2'd0, 32'hFFFF_F800,  32'h0000_0293, {1'b0, 32'h8000_0293});
    drain();
    asserts++;
    if (err_cnt !== 8'd2) begin
      fails++;
      $display("FAIL err_cnt_after_errors: got %0d, expected 2", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          logic [1:0]  f;
          logic [31:0] i, b;
          f = 2'($urandom_range(0, 3));
          i = rand_imm();
          b = $urandom;
          send(f, i, b, model(f, i, b));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        asserts++;
        if ({in_ready, out_valid} !== 2'b01) begin
          fails++;
          $display("FAIL stall_ready: in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [1:0]  f;
          logic [31:0] i, b;
          f = 2'($urandom_range(0, 3));
          i = rand_imm();
          b = $urandom;
          send(f, i, b, model(f, i, b));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain();
  endtask

  task automatic test_wrap();
    logic [3:0] wexp[4];
    wexp = '{4'd8, 4'd12, 4'd0, 4'd4};
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    m_addr = 32'd0;
    m_cnt  = 8'd0;
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send(2'd0, 32'(k), 32'h0000_0013, model(2'd0, 32'(k), 32'h0000_0013));
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int g;
          g = 0;
          @(negedge clk);
          while (!w_out_valid && g < 10) begin
            @(negedge clk);
            g++;
          end
          asserts++;
          if (!w_out_valid || w_addr !== wexp[k]) begin
            fails++;
            $display("FAIL wrap_addr: word %0d valid=%b addr=%0d, expected addr %0d",
                     k, w_out_valid, w_addr, wexp[k]);
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_saturation();
    logic [32:0] ex;
    ex = model(2'd2, 32'd1, 32'h0000_0063);
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      send(2'd2, 32'd1, 32'h0000_0063, ex);
    end
    drain();
    asserts++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL err_cnt_saturate: got %0d, expected 255", err_cnt);
    end
  endtask

  task automatic test_clr();
    out_ready = 1'b0;
    send(2'd0, 32'd5, 32'h0000_0013, model(2'd0, 32'd5, 32'h0000_0013));
    send(2'd1, 32'd8, 32'h0000_0023, model(2'd1, 32'd8, 32'h0000_0023));
    fmt = 2'd0; imm = 32'd7; base = 32'h0000_0013; in_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_in_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_addr = 32'd0;
    m_cnt  = 8'd0;
    @(negedge clk);
    asserts++;
    if ({out_valid, out_addr, err_cnt} !== {1'b0, 32'd0, 8'd0}) begin
      fails++;
      $display("FAIL clr_state: valid=%b addr=%h cnt=%0d, expected 0 0 0", out_valid, out_addr, err_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL clr_no_accept: cycle %0d out_valid=%b, expected 0", k, out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send(2'd0, 32'd4096, 32'h0000_0013, model(2'd0, 32'd4096, 32'h0000_0013));
    send(2'd3, 32'd3,    32'h0000_006F, model(2'd3, 32'd3,    32'h0000_006F));
    drain();
    out_ready = 1'b0;
    send(2'd0, 32'd9,  32'h0000_0013, model(2'd0, 32'd9,  32'h0000_0013));
    send(2'd0, 32'd10, 32'h0000_0013, model(2'd0, 32'd10, 32'h0000_0013));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    asserts++;
    if ({out_valid, instr, err, out_addr, err_cnt, in_ready} !== {1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset: valid=%b instr=%h err=%b addr=%h cnt=%0d rdy=%b, expected 0 0 0 0 0 1",
               out_valid, instr, err, out_addr, err_cnt, in_ready);
    end
    asserts++;
    if (w_addr !== 4'd8) begin
      fails++;
      $display("FAIL async_reset_base: got %h, expected 8", w_addr);
    end
    exp_q.delete();
    m_addr = 32'd0;
    m_cnt  = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'd1, 32'hFFFF_FFFC, 32'h0011_2023, model(2'd1, 32'hFFFF_FFFC, 32'h0011_2023));
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_backpressure();
    test_random();
    test_wrap();
    test_saturation();
    test_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
